// File: rtl/alu_exec_pkg.sv
// Shared encodings for the execute-stage ALU: alu_ctl codes, aluop classes,
// funct values and status bit positions.
package alu_exec_pkg;

    typedef logic [2:0] alu_ctl_t;

    localparam alu_ctl_t CTL_AND = 3'b000;
    localparam alu_ctl_t CTL_OR  = 3'b001;
    localparam alu_ctl_t CTL_ADD = 3'b010;
    localparam alu_ctl_t CTL_SLL = 3'b011;
    localparam alu_ctl_t CTL_NOR = 3'b100;
    localparam alu_ctl_t CTL_SRL = 3'b101;
    localparam alu_ctl_t CTL_SUB = 3'b110;
    localparam alu_ctl_t CTL_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    localparam int STS_Z = 0;
    localparam int STS_N = 1;
    localparam int STS_V = 2;

endpackage

// File: rtl/alu_exec_if.sv
// Operand, control and result bundle between the decode/PC logic and the
// execute-stage ALU.
interface alu_exec_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        stswrite;
    logic [31:0] pc;
    logic [31:0] branch_off;
    logic [31:0] result;
    logic        zero;
    logic [2:0]  alu_ctl;
    logic [2:0]  status;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    modport master (
        output a, b, aluop, funct, stswrite, pc, branch_off,
        input  result, zero, alu_ctl, status, pc_plus4, branch_target
    );

    modport slave (
        input  a, b, aluop, funct, stswrite, pc, branch_off,
        output result, zero, alu_ctl, status, pc_plus4, branch_target
    );
endinterface

// File: rtl/alu_exec_add32.sv
// 32-bit modulo adder used for the PC+4 and branch-target paths.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a + b;
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU with registered {V,N,Z}
// status, and the PC adders. Shifts exist only when ALU_SHIFT_EN is defined.
module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    alu_exec_if.slave bus
);

    alu_ctl_t    ctl;
    logic [31:0] res;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        ovf_add;
    logic        ovf_sub;
    logic        ovf;
    logic [2:0]  flags;
    logic [2:0]  status_q;
    logic [31:0] pc4;
    logic [31:0] bt;

    always_comb begin
        ctl = CTL_ADD;
        case (bus.aluop)
            ALUOP_ADD: ctl = CTL_ADD;
            ALUOP_SUB: ctl = CTL_SUB;
            ALUOP_OR:  ctl = CTL_OR;
            default: begin
                case (bus.funct)
                    FUNCT_ADD: ctl = CTL_ADD;
                    FUNCT_SUB: ctl = CTL_SUB;
                    FUNCT_AND: ctl = CTL_AND;
                    FUNCT_OR:  ctl = CTL_OR;
                    FUNCT_NOR: ctl = CTL_NOR;
                    FUNCT_SLT: ctl = CTL_SLT;
`ifdef ALU_SHIFT_EN
                    FUNCT_SLL: ctl = CTL_SLL;
                    FUNCT_SRL: ctl = CTL_SRL;
`endif
                    default:   ctl = CTL_ADD;
                endcase
            end
        endcase
    end

    assign sum     = bus.a + bus.b;
    assign diff    = bus.a - bus.b;
    assign ovf_add = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
    assign ovf_sub = (bus.a[31] != bus.b[31]) && (diff[31] != bus.a[31]);

    // SLT uses sign-of-difference corrected by overflow so extremes compare right
    always_comb begin
        res = 32'h0;
        ovf = 1'b0;
        case (ctl)
            CTL_AND: res = bus.a & bus.b;
            CTL_OR:  res = bus.a | bus.b;
            CTL_NOR: res = ~(bus.a | bus.b);
            CTL_ADD: begin
                res = sum;
                ovf = ovf_add;
            end
            CTL_SUB: begin
                res = diff;
                ovf = ovf_sub;
            end
            CTL_SLT: res = {31'h0, diff[31] ^ ovf_sub};
`ifdef ALU_SHIFT_EN
            CTL_SLL: res = bus.a << bus.b[4:0];
            CTL_SRL: res = bus.a >> bus.b[4:0];
`endif
            default: res = 32'h0;
        endcase
    end

    always_comb begin
        flags        = 3'b000;
        flags[STS_Z] = (res == 32'h0);
        flags[STS_N] = res[31];
        flags[STS_V] = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 3'b000;
        end else if (bus.stswrite) begin
            status_q <= flags;
        end
    end

    add32 u_pc_plus4 (
        .a (bus.pc),
        .b (32'd4),
        .y (pc4)
    );

    add32 u_branch_target (
        .a (pc4),
        .b (bus.branch_off),
        .y (bt)
    );

    assign bus.result        = res;
    assign bus.zero          = flags[STS_Z];
    assign bus.alu_ctl       = ctl;
    assign bus.status        = status_q;
    assign bus.pc_plus4      = pc4;
    assign bus.branch_target = bt;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: the driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;
    alu_exec_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_SHIFT_EN
    localparam logic [31:0] SLL_R = 32'h8000_0000;
    localparam logic [2:0]  SLL_C = 3'b011;
    localparam logic [31:0] SRL_R = 32'h0800_0000;
    localparam logic [2:0]  SRL_C = 3'b101;
    localparam logic [2:0]  ST_AFTER_SLL = 3'b010;
    localparam logic [2:0]  ST_AFTER_SRL = 3'b000;
`else
    localparam logic [31:0] SLL_R = 32'h0000_0020;
    localparam logic [2:0]  SLL_C = 3'b010;
    localparam logic [31:0] SRL_R = 32'h8000_0004;
    localparam logic [2:0]  SRL_C = 3'b010;
    localparam logic [2:0]  ST_AFTER_SLL = 3'b000;
    localparam logic [2:0]  ST_AFTER_SRL = 3'b010;
`endif

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic        sw;
        logic [31:0] pc;
        logic [31:0] boff;
        int          rmode;   // 0 release reset, 1 assert mid-cycle, 2 keep asserted
        logic [31:0] er;
        logic        ez;
        logic [2:0]  ectl;
        logic [2:0]  est;
        logic [31:0] ep4;
        logic [31:0] ebt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] er;
        logic        ez;
        logic [2:0]  ectl;
        logic [2:0]  est;
        logic [31:0] ep4;
        logic [31:0] ebt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic chk_valid;
    int   total;
    int   bad;

    task automatic add_vec(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [31:0] a, input logic [31:0] b, input logic sw,
                           input logic [31:0] pc, input logic [31:0] boff, input int rmode,
                           input logic [31:0] er, input logic ez, input logic [2:0] ectl,
                           input logic [2:0] est, input logic [31:0] ep4, input logic [31:0] ebt);
        vec_t v;
        v.aluop = aluop; v.funct = funct; v.a = a; v.b = b; v.sw = sw;
        v.pc = pc; v.boff = boff; v.rmode = rmode;
        v.er = er; v.ez = ez; v.ectl = ectl; v.est = est; v.ep4 = ep4; v.ebt = ebt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty got=0 expected=1");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",        e.idx, bus.result,               e.er);
                check("zero",          e.idx, {31'h0, bus.zero},        {31'h0, e.ez});
                check("alu_ctl",       e.idx, {29'h0, bus.alu_ctl},     {29'h0, e.ectl});
                check("status",        e.idx, {29'h0, bus.status},      {29'h0, e.est});
                check("pc_plus4",      e.idx, bus.pc_plus4,             e.ep4);
                check("branch_target", e.idx, bus.branch_target,        e.ebt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        chk_valid = 1'b0;
        rst_n = 1'b0;
        bus.a = '0; bus.b = '0; bus.aluop = 2'b00; bus.funct = '0;
        bus.stswrite = 1'b0; bus.pc = '0; bus.branch_off = '0;

        //       aluop  funct      a             b             sw  pc            boff          rm  result        z  ctl     status  pc4           bt
        add_vec(2'b00, 6'h00,     32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 3'b010, 3'b000, 32'h4,        32'h4);
        add_vec(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1,        1, 32'h10,       32'hFFFFFFF8, 0, 32'h80000000, 0, 3'b010, 3'b000, 32'h14,       32'h0C);
        add_vec(2'b01, 6'h00,     32'h1234,     32'h1234,     1, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        1, 3'b110, 3'b110, 32'h0,        32'h0);
        add_vec(2'b11, 6'h00,     32'hF0,       32'h0F,       0, 32'h100,      32'h20,       0, 32'hFF,       0, 3'b001, 3'b001, 32'h104,      32'h124);
        add_vec(2'b10, 6'b100111, 32'h0,        32'h0,        0, 32'h100,      32'h20,       0, 32'hFFFFFFFF, 0, 3'b100, 3'b001, 32'h104,      32'h124);
        add_vec(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1,        1, 32'h100,      32'h20,       0, 32'h1,        0, 3'b111, 3'b001, 32'h104,      32'h124);
        add_vec(2'b10, 6'b101010, 32'h80000000, 32'h1,        0, 32'h100,      32'h20,       0, 32'h1,        0, 3'b111, 3'b000, 32'h104,      32'h124);
        add_vec(2'b10, 6'b111111, 32'h5,        32'h6,        1, 32'h100,      32'h20,       0, 32'hB,        0, 3'b010, 3'b000, 32'h104,      32'h124);
        add_vec(2'b10, 6'b000000, 32'h1,        32'h1F,       1, 32'h100,      32'h20,       0, SLL_R,        0, SLL_C,  3'b000, 32'h104,      32'h124);
        add_vec(2'b10, 6'b000010, 32'h80000000, 32'h4,        1, 32'h100,      32'h20,       0, SRL_R,        0, SRL_C,  ST_AFTER_SLL, 32'h104, 32'h124);
        add_vec(2'b10, 6'b100100, 32'hFF00FF00, 32'h0F0F0F0F, 0, 32'h100,      32'h20,       0, 32'h0F000F00, 0, 3'b000, ST_AFTER_SRL, 32'h104, 32'h124);
        add_vec(2'b10, 6'b100010, 32'h80000000, 32'h1,        1, 32'h100,      32'h20,       0, 32'h7FFFFFFF, 0, 3'b110, ST_AFTER_SRL, 32'h104, 32'h124);
        add_vec(2'b10, 6'b100101, 32'h0,        32'h0,        0, 32'h100,      32'h20,       0, 32'h0,        1, 3'b001, 3'b100, 32'h104,      32'h124);
        add_vec(2'b00, 6'h00,     32'h7FFFFFFF, 32'h1,        1, 32'h100,      32'h20,       1, 32'h80000000, 0, 3'b010, 3'b000, 32'h104,      32'h124);
        add_vec(2'b00, 6'h00,     32'h7FFFFFFF, 32'h1,        1, 32'h100,      32'h20,       2, 32'h80000000, 0, 3'b010, 3'b000, 32'h104,      32'h124);
        add_vec(2'b00, 6'h00,     32'hFFFFFFFF, 32'h1,        1, 32'h100,      32'h20,       0, 32'h0,        1, 3'b010, 3'b000, 32'h104,      32'h124);
        add_vec(2'b01, 6'h00,     32'h1,        32'h2,        0, 32'h100,      32'h20,       0, 32'hFFFFFFFF, 0, 3'b110, 3'b001, 32'h104,      32'h124);

        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clk);
            #1;
            if (vecs[i].rmode == 0) rst_n = 1'b1;
            bus.aluop      = vecs[i].aluop;
            bus.funct      = vecs[i].funct;
            bus.a          = vecs[i].a;
            bus.b          = vecs[i].b;
            bus.stswrite   = vecs[i].sw;
            bus.pc         = vecs[i].pc;
            bus.branch_off = vecs[i].boff;
            e.idx = i; e.er = vecs[i].er; e.ez = vecs[i].ez; e.ectl = vecs[i].ectl;
            e.est = vecs[i].est; e.ep4 = vecs[i].ep4; e.ebt = vecs[i].ebt;
            sb.push_back(e);
            chk_valid = 1'b1;
            if (vecs[i].rmode == 1) begin
                #1;
                rst_n = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        bus.stswrite = 1'b0;
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
